// File: rtl/arcade_input_if.sv
// Player-input bundle between the hps_io side (master) and the input mapper (slave).
// Carries raw keyboard/joystick sources, rotation/coin controls and the mapped outputs.
interface arcade_input_if #(
  parameter int NUM_BUTTONS = 1
);
  logic [10:0]              ps2_key;
  logic [15:0]              joystick_0;
  logic [15:0]              joystick_1;
  logic [1:0]               rotate;
  logic                     coin_auto;
  logic [4+NUM_BUTTONS-1:0] p1_ctrl;
  logic [4+NUM_BUTTONS-1:0] p2_ctrl;
  logic [1:0]               start;
  logic                     coin;

  modport master (
    output ps2_key, joystick_0, joystick_1, rotate, coin_auto,
    input  p1_ctrl, p2_ctrl, start, coin
  );

  modport slave (
    input  ps2_key, joystick_0, joystick_1, rotate, coin_auto,
    output p1_ctrl, p2_ctrl, start, coin
  );
endinterface

// File: rtl/arcade_input_mapper.sv
// Arcade player-input front end: PS/2 key tracking, keyboard/joystick merge,
// per-player control rotation, registered outputs and a stretched coin pulse.
module arcade_input_mapper #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BUTTONS = 1,
  parameter int COIN_PULSE  = 16,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  arcade_input_if.slave  io
);

  localparam int   CW    = 4 + NUM_BUTTONS;
  localparam int   CNT_W = $clog2(COIN_PULSE + 1);
  localparam logic POL   = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} coin_state_t;

  // Remap {U,D,L,R} for a rotated cabinet.
  function automatic logic [3:0] rotate_dirs(input logic [3:0] d, input logic [1:0] r);
    case (r)
      2'd1:    rotate_dirs = {d[1], d[0], d[2], d[3]};
      2'd2:    rotate_dirs = {d[2], d[3], d[0], d[1]};
      2'd3:    rotate_dirs = {d[0], d[1], d[3], d[2]};
      default: rotate_dirs = d;
    endcase
  endfunction

  // Buttons pass straight through; only the direction nibble rotates.
  function automatic logic [CW-1:0] rotate_ctrl(input logic [CW-1:0] v, input logic [1:0] r);
    rotate_ctrl = {v[CW-1:4], rotate_dirs(v[3:0], r)};
  endfunction

  logic        armed;
  logic        old_toggle;
  logic [3:0]  kbd_dir;
  logic [3:0]  kbd_btn;
  logic [1:0]  kbd_start;
  logic        kbd_coin;

  logic [CW-1:0] p1_raw, p2_raw;
  logic [1:0]    start_raw;
  logic          coin_src;

  logic [CW-1:0] p1_p0, p2_p0;
  logic [1:0]    start_p0;
  logic          coin_p0;
  logic          src_p0;
  coin_state_t   state;
  logic [CNT_W-1:0] cnt;

  logic unused_bits;
  assign unused_bits = ^{io.joystick_0, io.joystick_1, kbd_btn};

  // Track PS/2 events by toggle bit and latch the pressed state of mapped keys.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      armed      <= 1'b0;
      old_toggle <= 1'b0;
      kbd_dir    <= '0;
      kbd_btn    <= '0;
      kbd_start  <= '0;
      kbd_coin   <= 1'b0;
    end else begin
      old_toggle <= io.ps2_key[10];
      armed      <= 1'b1;
      // The first clock after reset only learns the toggle phase, so a stale event is not replayed.
      if (armed && (io.ps2_key[10] != old_toggle)) begin
        // Arrows match with or without the E0 prefix so keypad and cursor keys both work.
        case (io.ps2_key[7:0])
          8'h75: kbd_dir[3] <= io.ps2_key[9];
          8'h72: kbd_dir[2] <= io.ps2_key[9];
          8'h6B: kbd_dir[1] <= io.ps2_key[9];
          8'h74: kbd_dir[0] <= io.ps2_key[9];
          default: ;
        endcase
        case (io.ps2_key[8:0])
          9'h014, 9'h029: kbd_btn[0] <= io.ps2_key[9];
          9'h011: if (NUM_BUTTONS > 1) kbd_btn[1] <= io.ps2_key[9];
          9'h012: if (NUM_BUTTONS > 2) kbd_btn[2] <= io.ps2_key[9];
          9'h01A: if (NUM_BUTTONS > 3) kbd_btn[3] <= io.ps2_key[9];
          9'h005: kbd_start[0] <= io.ps2_key[9];
          9'h006: kbd_start[1] <= io.ps2_key[9];
          9'h02E: kbd_coin     <= io.ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  // Merge keyboard into player 1, gate player 2 when single-player, build the coin source.
  always_comb begin
    p1_raw       = {kbd_btn[NUM_BUTTONS-1:0], kbd_dir} | io.joystick_0[CW-1:0];
    p2_raw       = (NUM_PLAYERS == 2) ? io.joystick_1[CW-1:0] : '0;
    start_raw    = '0;
    start_raw[0] = kbd_start[0] | io.joystick_0[4+NUM_BUTTONS];
    if (NUM_PLAYERS == 2)
      start_raw[1] = kbd_start[1] | io.joystick_1[4+NUM_BUTTONS];
    coin_src = kbd_coin | io.joystick_0[5+NUM_BUTTONS] | io.joystick_1[5+NUM_BUTTONS]
             | (io.coin_auto & (|start_raw));
  end

  // Output stage p0: rotated control words and starts, held in active-high form.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      p1_p0    <= '0;
      p2_p0    <= '0;
      start_p0 <= '0;
    end else begin
      p1_p0    <= rotate_ctrl(p1_raw, io.rotate);
      p2_p0    <= rotate_ctrl(p2_raw, io.rotate);
      start_p0 <= start_raw;
    end
  end

  // Coin FSM: one fixed-width pulse per rising edge of the source, no retrigger until it drops.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      coin_p0 <= 1'b0;
      src_p0  <= 1'b0;
    end else begin
      src_p0 <= coin_src;
      case (state)
        IDLE: begin
          if (coin_src && !src_p0) begin
            state   <= PULSE;
            cnt     <= CNT_W'(COIN_PULSE - 1);
            coin_p0 <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state   <= HOLD;
            coin_p0 <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (!coin_src) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          coin_p0 <= 1'b0;
        end
      endcase
    end
  end

  assign io.p1_ctrl = p1_p0 ^ {CW{POL}};
  assign io.p2_ctrl = p2_p0 ^ {CW{POL}};
  assign io.start   = start_p0 ^ {2{POL}};
  assign io.coin    = coin_p0 ^ POL;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper (2 players, 1 button, 16-cycle coin, active-low outputs).
// Stimulus queues expected outputs tagged with the cycle they are due; a monitor checks them.
module tb_arcade_input_mapper;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic tog = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arcade_input_if #(.NUM_BUTTONS(1)) bus ();

  arcade_input_mapper #(
    .NUM_PLAYERS(2), .NUM_BUTTONS(1), .COIN_PULSE(16), .ACTIVE_LOW(1)
  ) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .io      (bus)
  );

  // Expected values are written active-high (1 = pressed); the monitor inverts them.
  typedef struct {
    int         due;
    bit         full;
    logic [4:0] p1;
    logic [4:0] p2;
    logic [1:0] st;
    logic       coin;
    string      name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  task automatic expect_full(int d, logic [4:0] p1, logic [4:0] p2, logic [1:0] st,
                             logic c, string nm);
    exp_t e;
    e.due = cyc + d; e.full = 1'b1; e.p1 = p1; e.p2 = p2; e.st = st; e.coin = c; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic expect_coin(int d, logic c, string nm);
    exp_t e;
    e.due = cyc + d; e.full = 1'b0; e.p1 = '0; e.p2 = '0; e.st = '0; e.coin = c; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_evt(logic pressed, logic [8:0] code);
    tog = ~tog;
    bus.ps2_key = {tog, pressed, code};
  endtask

  // Monitor: on each falling edge, check every expectation due now.
  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due <= cyc) begin
        mon_e = sbq[i];
        sbq.delete(i);
        checks++;
        if (mon_e.due < cyc) begin
          errors++;
          $display("FAIL %s: check missed, due cycle %0d, now %0d", mon_e.name, mon_e.due, cyc);
        end else if (mon_e.full) begin
          if ({bus.p1_ctrl, bus.p2_ctrl, bus.start, bus.coin} !==
              {~mon_e.p1, ~mon_e.p2, ~mon_e.st, ~mon_e.coin}) begin
            errors++;
            $display("FAIL %s @%0d: got p1=%h p2=%h start=%b coin=%b, want p1=%h p2=%h start=%b coin=%b",
                     mon_e.name, cyc, bus.p1_ctrl, bus.p2_ctrl, bus.start, bus.coin,
                     ~mon_e.p1, ~mon_e.p2, ~mon_e.st, ~mon_e.coin);
          end
        end else begin
          if (bus.coin !== ~mon_e.coin) begin
            errors++;
            $display("FAIL %s @%0d: got coin=%b, want coin=%b", mon_e.name, cyc, bus.coin, ~mon_e.coin);
          end
        end
      end
    end
  end

  initial begin
    bus.ps2_key    = '0;
    bus.joystick_0 = '0;
    bus.joystick_1 = '0;
    bus.rotate     = 2'd0;
    bus.coin_auto  = 1'b0;
    reset_n        = 1'b1;
    #2 reset_n     = 1'b0;

    // Reset: activity on the inputs must not reach the outputs.
    tick(1);
    expect_full(0, 5'h00, 5'h00, 2'b00, 1'b0, "reset_idle");
    ps2_evt(1'b1, 9'h175);
    bus.joystick_0 = 16'h000F;
    bus.joystick_1 = 16'h0030;
    tick(1);
    expect_full(0, 5'h00, 5'h00, 2'b00, 1'b0, "reset_hold");
    tick(1);
    bus.joystick_0 = '0;
    bus.joystick_1 = '0;
    reset_n = 1'b1;
    for (int d = 1; d <= 3; d++) expect_full(d, 5'h00, 5'h00, 2'b00, 1'b0, "no_decode_after_reset");
    tick(4);

    // Extended up arrow: two-cycle latency on press and release.
    ps2_evt(1'b1, 9'h175);
    expect_full(1, 5'h00, 5'h00, 2'b00, 1'b0, "e075_lat1");
    expect_full(2, 5'h08, 5'h00, 2'b00, 1'b0, "e075_press");
    tick(3);
    ps2_evt(1'b0, 9'h175);
    expect_full(1, 5'h08, 5'h00, 2'b00, 1'b0, "e075_hold");
    expect_full(2, 5'h00, 5'h00, 2'b00, 1'b0, "e075_release");
    tick(3);
    ps2_evt(1'b1, 9'h072);
    expect_full(2, 5'h04, 5'h00, 2'b00, 1'b0, "kp_down_press");
    tick(3);
    ps2_evt(1'b0, 9'h072);
    expect_full(2, 5'h00, 5'h00, 2'b00, 1'b0, "kp_down_release");
    tick(3);

    // Rotation of joystick directions.
    bus.joystick_0 = 16'h0002;
    expect_full(1, 5'h02, 5'h00, 2'b00, 1'b0, "rot0_L");
    tick(2);
    bus.rotate = 2'd1;
    expect_full(1, 5'h08, 5'h00, 2'b00, 1'b0, "rot1_L_to_U");
    tick(2);
    bus.rotate = 2'd3;
    expect_full(1, 5'h04, 5'h00, 2'b00, 1'b0, "rot3_L_to_D");
    tick(2);
    bus.rotate = 2'd2;
    bus.joystick_0 = 16'h0011;
    expect_full(1, 5'h12, 5'h00, 2'b00, 1'b0, "rot2_R_to_L_btn");
    tick(2);
    bus.rotate = 2'd1;
    bus.joystick_0 = 16'h0008;
    expect_full(1, 5'h01, 5'h00, 2'b00, 1'b0, "rot1_U_to_R");
    tick(2);
    bus.rotate = 2'd0;
    bus.joystick_0 = '0;
    expect_full(1, 5'h00, 5'h00, 2'b00, 1'b0, "rot_clear");
    tick(2);

    // Keyboard/joystick merge with opposing directions.
    ps2_evt(1'b1, 9'h06B);
    bus.joystick_0 = 16'h0001;
    expect_full(1, 5'h01, 5'h00, 2'b00, 1'b0, "merge_joy_first");
    expect_full(2, 5'h03, 5'h00, 2'b00, 1'b0, "merge_LR");
    tick(3);
    ps2_evt(1'b0, 9'h06B);
    bus.joystick_0 = '0;
    expect_full(1, 5'h02, 5'h00, 2'b00, 1'b0, "merge_kbd_lags");
    expect_full(2, 5'h00, 5'h00, 2'b00, 1'b0, "merge_clear");
    tick(3);
    ps2_evt(1'b1, 9'h029);
    expect_full(2, 5'h10, 5'h00, 2'b00, 1'b0, "space_btn0");
    tick(3);
    ps2_evt(1'b0, 9'h029);
    expect_full(2, 5'h00, 5'h00, 2'b00, 1'b0, "space_release");
    tick(3);
    ps2_evt(1'b1, 9'h011);
    expect_full(2, 5'h00, 5'h00, 2'b00, 1'b0, "alt_ignored_nb1");
    tick(3);
    ps2_evt(1'b0, 9'h011);
    tick(3);

    // Player 2 joystick.
    bus.joystick_1 = 16'h000A;
    expect_full(1, 5'h00, 5'h0A, 2'b00, 1'b0, "p2_UL");
    tick(2);
    bus.joystick_1 = '0;
    expect_full(1, 5'h00, 5'h00, 2'b00, 1'b0, "p2_clear");
    tick(2);

    // Keyboard F1 start, no coin without coin_auto.
    ps2_evt(1'b1, 9'h005);
    expect_full(2, 5'h00, 5'h00, 2'b01, 1'b0, "f1_start0");
    tick(3);
    ps2_evt(1'b0, 9'h005);
    expect_full(2, 5'h00, 5'h00, 2'b00, 1'b0, "f1_release");
    tick(3);

    // P2 start with coin_auto off: start only.
    bus.joystick_1 = 16'h0020;
    expect_full(1, 5'h00, 5'h00, 2'b10, 1'b0, "p2_start_noauto");
    for (int d = 1; d <= 20; d++) expect_coin(d, 1'b0, "noauto_coin");
    tick(21);
    bus.joystick_1 = '0;
    expect_full(1, 5'h00, 5'h00, 2'b00, 1'b0, "p2_start_release");
    tick(3);

    // P2 start with coin_auto on: 16-cycle coin.
    bus.coin_auto = 1'b1;
    bus.joystick_1 = 16'h0020;
    expect_full(1, 5'h00, 5'h00, 2'b10, 1'b1, "p2_start_auto");
    for (int d = 1; d <= 30; d++) expect_coin(d, (d <= 16), "auto_coin_width");
    tick(31);
    bus.joystick_1 = '0;
    bus.coin_auto = 1'b0;
    expect_full(1, 5'h00, 5'h00, 2'b00, 1'b0, "auto_release");
    tick(3);

    // '5' held for 100 cycles: single 16-cycle pulse starting two cycles after the event.
    ps2_evt(1'b1, 9'h02E);
    for (int d = 1; d <= 100; d++) expect_coin(d, (d >= 2 && d <= 17), "key5_coin_width");
    tick(101);
    ps2_evt(1'b0, 9'h02E);
    for (int d = 1; d <= 10; d++) expect_coin(d, 1'b0, "key5_release");
    tick(11);

    // Joystick 0 coin bit.
    bus.joystick_0 = 16'h0040;
    for (int d = 1; d <= 20; d++) expect_coin(d, (d <= 16), "joy0_coin_width");
    tick(21);
    bus.joystick_0 = '0;
    tick(3);

    // Reset in the middle of a pulse.
    ps2_evt(1'b1, 9'h02E);
    expect_coin(1, 1'b0, "mid_pre");
    for (int d = 2; d <= 5; d++) expect_coin(d, 1'b1, "mid_pulse");
    tick(6);
    reset_n = 1'b0;
    expect_full(0, 5'h00, 5'h00, 2'b00, 1'b0, "reset_mid_pulse");
    tick(1);
    ps2_evt(1'b0, 9'h02E);
    tick(2);
    reset_n = 1'b1;
    for (int d = 1; d <= 25; d++) expect_full(d, 5'h00, 5'h00, 2'b00, 1'b0, "no_residual_pulse");
    tick(26);

    for (int i = 0; i < 50 && sbq.size() != 0; i++) tick(1);
    if (sbq.size() != 0) begin
      errors += sbq.size();
      checks += sbq.size();
      $display("FAIL drain: %0d expectations never checked, want 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
